data_mem_mmio: RTL and testbench



---
 rtl/mmio_pkg.sv | 23 ++
 rtl/uart_tx_shifter.sv | 87 ++++++++
 rtl/data_mem_mmio.sv | 118 +++++++++++
 tb/tb_data_mem_mmio.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the data-side memory/MMIO block: address map, STATUS bit
// positions, transmit state encodings and TX FIFO depth.
package mmio_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'h0001_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h0001_0004;
    localparam logic [31:0] CYCLE_ADDR  = 32'h0001_0008;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;
    localparam int STATUS_OVF_BIT  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int TXFIFO_DEPTH = 4;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit. `ready` marks the cycles
// in which a load is taken: IDLE, or the last cycle of STOP for back-to-back frames.
module uart_tx_shifter
    import mmio_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign ready   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign busy    = (state_q != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
        end
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx      = 1'b1;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (load) begin
                    shreg_d = data_in;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx = shreg_q[0];
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                // Reloading here chains the next start bit directly onto this stop bit.
                if (bit_end) begin
                    if (load) begin
                        shreg_d = data_in;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory: word RAM plus MMIO UART TX (TXDATA/STATUS) and CYCLE counter.
// Define MMIO_TXFIFO_EN to put a 4-entry FIFO in front of the UART shifter.
module data_mem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int CLK_DIV   = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic [1:0]    unused_addr_lsbs;
    logic          sel_ram, sel_tx, sel_status, sel_cycle;
    logic          wr_tx;
    logic [31:0]   cycle_q;
    logic          ovf_q;
    logic          tx_busy, tx_full, sh_ready, sh_load;
    logic [7:0]    sh_data;

    assign unused_addr_lsbs = Mem_WrAddr[1:0];
    assign word_addr  = {Mem_WrAddr[31:2], 2'b00};
    assign ram_idx    = Mem_WrAddr[AW+1:2];
    assign sel_ram    = (Mem_WrAddr[31:AW+2] == '0);
    assign sel_tx     = (word_addr == TXDATA_ADDR);
    assign sel_status = (word_addr == STATUS_ADDR);
    assign sel_cycle  = (word_addr == CYCLE_ADDR);
    assign wr_tx      = MemWrite && sel_tx;

    always_ff @(posedge clk) begin
        if (MemWrite && sel_ram) ram[ram_idx] <= Mem_WrData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= (MemWrite && sel_cycle) ? Mem_WrData : cycle_q + 32'd1;
            // Set wins over a same-cycle clear.
            if (wr_tx && tx_full)
                ovf_q <= 1'b1;
            else if (MemWrite && sel_status && Mem_WrData[STATUS_OVF_BIT])
                ovf_q <= 1'b0;
        end
    end

`ifdef MMIO_TXFIFO_EN
    localparam int PW = $clog2(TXFIFO_DEPTH);

    logic [7:0]    fifo_mem [TXFIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop;

    assign tx_full = (count_q == (PW+1)'(TXFIFO_DEPTH));
    assign push    = wr_tx && !tx_full;
    assign pop     = (count_q != '0) && sh_ready;
    assign sh_load = pop;
    assign sh_data = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= Mem_WrData[7:0];
    end
`else
    assign tx_full = tx_busy;
    assign sh_load = wr_tx && !tx_full && sh_ready;
    assign sh_data = Mem_WrData[7:0];
`endif

    uart_tx_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .data_in (sh_data),
        .load    (sh_load),
        .ready   (sh_ready),
        .busy    (tx_busy),
        .tx      (uart_tx)
    );

    always_comb begin
        ReadData = '0;
        if (sel_ram) begin
            ReadData = ram[ram_idx];
        end else if (sel_status) begin
            ReadData[STATUS_BUSY_BIT] = tx_busy;
            ReadData[STATUS_FULL_BIT] = tx_full;
            ReadData[STATUS_OVF_BIT]  = ovf_q;
        end else if (sel_cycle) begin
            ReadData = cycle_q;
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: frame-level behavioural model plus directed
// literal checks and a randomized phase. Works with or without MMIO_TXFIFO_EN.
module tb_data_mem_mmio;

    localparam int RAM_WORDS = 64;
    localparam int CLK_DIV   = 4;
    localparam int FRAME     = 10 * CLK_DIV;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [31:0] A_TX = 32'h0001_0000;
    localparam logic [31:0] A_ST = 32'h0001_0004;
    localparam logic [31:0] A_CY = 32'h0001_0008;
`ifdef MMIO_TXFIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = '0;
    logic [31:0] Mem_WrData = '0;
    logic [31:0] ReadData;
    logic        uart_tx;

    always #5 clk = ~clk;

    data_mem_mmio #(
        .RAM_WORDS (RAM_WORDS),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .uart_tx    (uart_tx)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model state: RAM image, CYCLE, overflow, the current frame and a byte queue.
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_wr  [RAM_WORDS];
    logic [31:0] m_cycle = '0;
    bit          m_ovf = 1'b0;
    bit          fr_on = 1'b0;
    int          fr_start = 0;
    logic [7:0]  fr_byte = '0;
    logic [7:0]  q [$];

    logic [31:0] s_rd;
    logic        s_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return fr_on && (c >= fr_start) && (c < fr_start + FRAME);
    endfunction

    function automatic logic m_line(input int c);
        int k;
        if (!m_busy(c)) return 1'b1;
        k = (c - fr_start) / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr_byte[k-1];
    endfunction

    function automatic bit m_full(input int c);
`ifdef MMIO_TXFIFO_EN
        return q.size() == 4;
`else
        return m_busy(c);
`endif
    endfunction

    // Returns 0 when the expected value is unknown (never-written RAM word).
    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        v = '0;
        if (w < RAM_BYTES) begin
            v = m_ram[w >> 2];
            return m_wr[w >> 2];
        end
        if (w == A_ST) v = {29'd0, m_ovf, m_full(cyc), m_busy(cyc)};
        else if (w == A_CY) v = m_cycle;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        bit busy, full, wtx;
        w    = a & 32'hFFFF_FFFC;
        busy = m_busy(cyc);
        full = m_full(cyc);
        wtx  = we && (w == A_TX);
        if (we && (w < RAM_BYTES)) begin
            m_ram[w >> 2] = d;
            m_wr[w >> 2]  = 1'b1;
        end
        if (r) begin
            fr_on = 1'b0;
            q.delete();
            m_ovf   = 1'b0;
            m_cycle = '0;
            return;
        end
        m_cycle = (we && (w == A_CY)) ? d : m_cycle + 32'd1;
        if (wtx && full) m_ovf = 1'b1;
        else if (we && (w == A_ST) && d[2]) m_ovf = 1'b0;
`ifdef MMIO_TXFIFO_EN
        if ((q.size() > 0) && (!busy || (cyc == fr_start + FRAME - 1))) begin
            fr_byte  = q.pop_front();
            fr_start = cyc + 1;
            fr_on    = 1'b1;
        end
        if (wtx && !full) q.push_back(d[7:0]);
`else
        if (wtx && !full) begin
            fr_on    = 1'b1;
            fr_start = cyc + 1;
            fr_byte  = d[7:0];
        end
`endif
    endtask

    // One clock cycle: drive, sample mid-cycle, compare against the model, advance.
    task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        @(negedge clk);
        reset      = r;
        MemWrite   = we;
        Mem_WrAddr = a;
        Mem_WrData = d;
        #1;
        s_rd = ReadData;
        s_tx = uart_tx;
        if (chk_en) begin
            chk("model_uart_tx", {31'd0, s_tx}, {31'd0, m_line(cyc)});
            if (m_read(a, e)) chk("model_ReadData", s_rd, e);
        end
        @(posedge clk);
        model_edge(r, we, a, d);
        cyc++;
    endtask

    initial begin
        logic [9:0] frame_pat;
        int         gaps;
        int         n;
        frame_pat = 10'b1_1010_0101_0;

        // Reset state
        step(1'b1, 1'b0, A_ST, 32'd0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, A_ST, 32'd0);
        step(1'b0, 1'b0, A_CY, 32'd0);
        chk("reset_cycle", s_rd, 32'd0);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("reset_status", s_rd, 32'd0);
        chk("reset_tx", {31'd0, s_tx}, 32'd1);

        // RAM store then load
        step(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0000_0010, 32'd0);
        chk("ram_rd_10", s_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0000_0013, 32'd0);
        chk("ram_rd_13", s_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0002_0000, 32'd0);
        chk("unmapped_rd", s_rd, 32'd0);

        // Frame shape for 0xA5
        step(1'b0, 1'b1, A_TX, 32'h0000_00A5);
        for (int k = 1; k <= 41 + LAT; k++) begin
            step(1'b0, 1'b0, A_ST, 32'd0);
            if ((k - LAT >= 1) && (k - LAT <= 40))
                chk("frame_bit", {31'd0, s_tx}, {31'd0, frame_pat[(k - LAT - 1) / 4]});
            else
                chk("frame_idle", {31'd0, s_tx}, 32'd1);
            if (k == 40 + LAT) chk("busy_last", {31'd0, s_rd[0]}, 32'd1);
            if (k == 41 + LAT) chk("busy_clear", {31'd0, s_rd[0]}, 32'd0);
        end

`ifdef MMIO_TXFIFO_EN
        // Six back-to-back writes: five accepted, sixth overflows, frames chained
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, A_TX, 32'(8'h30 + k));
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("fifo_ovf_status", s_rd, 32'h7);
        gaps = 0;
        for (int k = 7; k < 2 + 5 * FRAME; k++) begin
            step(1'b0, 1'b0, A_ST, 32'd0);
            if (s_rd[0] == 1'b0) gaps++;
        end
        chk("fifo_no_gap", 32'(gaps), 32'd0);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("fifo_done", {31'd0, s_rd[0]}, 32'd0);
        step(1'b0, 1'b1, A_ST, 32'h4);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("fifo_ovf_clear", s_rd, 32'd0);
`else
        // Two consecutive writes: second dropped, overflow set then cleared
        step(1'b0, 1'b1, A_TX, 32'h11);
        step(1'b0, 1'b1, A_TX, 32'h22);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("ovf_status", s_rd, 32'h7);
        step(1'b0, 1'b1, A_ST, 32'h4);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("ovf_clear", s_rd, 32'h3);
        for (int k = 0; k < FRAME; k++) step(1'b0, 1'b0, A_ST, 32'd0);
        chk("ovf_idle", s_rd, 32'd0);
`endif

        // CYCLE load and wrap
        step(1'b0, 1'b1, A_CY, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, A_CY, 32'd0);
        chk("cycle_fe", s_rd, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, A_CY, 32'd0);
        chk("cycle_ff", s_rd, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, A_CY, 32'd0);
        chk("cycle_wrap", s_rd, 32'h0000_0000);

        // Reset mid-frame, then a fresh frame
        step(1'b0, 1'b1, A_TX, 32'h3C);
        for (int k = 1; k <= 12; k++) step(1'b0, 1'b0, A_ST, 32'd0);
        step(1'b1, 1'b0, A_ST, 32'd0);
        step(1'b0, 1'b0, A_ST, 32'd0);
        chk("midrst_status", s_rd, 32'd0);
        chk("midrst_tx", {31'd0, s_tx}, 32'd1);
        step(1'b0, 1'b1, A_TX, 32'h96);
        for (int k = 1; k <= FRAME + 2; k++) begin
            step(1'b0, 1'b0, A_ST, 32'd0);
            if (k == 1 + LAT) chk("post_rst_start", {31'd0, s_tx}, 32'd0);
        end
        chk("post_rst_idle", s_rd, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 99);
            if (n == 0)
                step(1'b1, 1'b0, A_ST, 32'd0);
            else if (n < 35)
                step(1'b0, 1'b1, 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom);
            else if (n < 55)
                step(1'b0, 1'b0, 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), 32'd0);
            else if (n < 65)
                step(1'b0, 1'b1, A_TX, $urandom);
            else if (n < 75)
                step(1'b0, 1'b0, A_ST, 32'd0);
            else if (n < 78)
                step(1'b0, 1'b1, A_ST, $urandom);
            else if (n < 88)
                step(1'b0, 1'b0, A_CY, 32'd0);
            else if (n < 89)
                step(1'b0, 1'b1, A_CY, $urandom);
            else if (n < 93)
                step(1'b0, 1'($urandom_range(0, 1)), RAM_BYTES + 32'($urandom_range(0, 15) * 4), $urandom);
            else if (n < 96)
                step(1'b0, 1'($urandom_range(0, 1)), 32'h0001_000C, $urandom);
            else
                step(1'b0, 1'b0, 32'h0001_0000 | 32'($urandom_range(0, 2) * 4 + $urandom_range(0, 3)), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
